tsetlin_state_update: RTL and testbench

- Upstream next-state stage for the 3-bit Tsetlin automaton state register.
- Accepts one feedback command per transaction (reward, penalty or inaction) through a valid/ready handshake.
- Computes the saturating next state and holds the current state internally.
- Drives next_b2/next_b1/next_b0, which wire directly to the b2/b1/b0 inputs of the downstream state register, plus the resulting include/exclude action.

---
 rtl/tsetlin_pkg.sv | 59 +++++
 rtl/tsetlin_lfsr.sv | 35 +++
 rtl/tsetlin_state_update.sv | 139 +++++++++++++
 tb/tb_tsetlin_state_update.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tsetlin_pkg.sv
// -----------------------------------------------------------------------------
// tsetlin_pkg
// Shared definitions for the Tsetlin automaton next-state stage:
//   - feedback command codes (FB_*)
//   - automaton state width and the include/exclude bit position
//   - FSM state encoding for the update controller
//   - ta_next(): saturating next-state rule for one feedback command
// -----------------------------------------------------------------------------
package tsetlin_pkg;

    localparam int TA_STATE_W     = 3;
    localparam int TA_INCLUDE_BIT = 2;

    localparam logic [1:0] FB_NONE    = 2'b00;
    localparam logic [1:0] FB_REWARD  = 2'b01;
    localparam logic [1:0] FB_PENALTY = 2'b10;
    localparam logic [1:0] FB_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        WRITE = 2'd2
    } ta_fsm_e;

    // Returns {skip, next_state}. Reward pushes the state deeper into its
    // current half (saturating at 0/7); penalty pushes it toward the 3/4
    // boundary and across it, so it can never wrap.
    function automatic logic [TA_STATE_W:0] ta_next(
        input logic [TA_STATE_W-1:0] s,
        input logic [1:0]            fb
    );
        logic [TA_STATE_W-1:0] nxt;
        logic                  skip;
        nxt  = s;
        skip = 1'b0;
        case (fb)
            FB_REWARD: begin
                if (s[TA_INCLUDE_BIT]) begin
                    nxt = (s == 3'd7) ? s : s + 3'd1;
                end else begin
                    nxt = (s == 3'd0) ? s : s - 3'd1;
                end
            end
            FB_PENALTY: begin
                if (s[TA_INCLUDE_BIT]) begin
                    nxt = s - 3'd1;
                end else begin
                    nxt = s + 3'd1;
                end
            end
            default: begin
                nxt  = s;
                skip = 1'b1;
            end
        endcase
        return {skip, nxt};
    endfunction

endpackage

// File: rtl/tsetlin_lfsr.sv
// -----------------------------------------------------------------------------
// tsetlin_lfsr
// 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1, free running.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, loads SEED
//   lfsr - current LFSR value
// SEED must be non-zero or the register locks up at zero.
// -----------------------------------------------------------------------------
module tsetlin_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_r;
    logic       fb_s;

    // Feedback taps at bits 8, 6, 5, 4 (1-based).
    assign fb_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];

    // Shift register, advances every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[6:0], fb_s};
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/tsetlin_state_update.sv
// -----------------------------------------------------------------------------
// tsetlin_state_update
// Next-state stage for a 3-bit Tsetlin automaton. Accepts one feedback command
// per transaction (IDLE -> EVAL -> WRITE), holds the current automaton state and
// drives it bit-wise to the downstream state register.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   fb_valid/fb_ready    - command handshake (ready only in IDLE)
//   fb_type              - 00 inaction, 01 reward, 10 penalty, 11 reserved
//   next_b2/b1/b0        - committed state bits (MSB first)
//   action               - include (1) / exclude (0), equals next_b2
//   upd_done             - one-cycle pulse after each commit
//   upd_skipped          - qualifies upd_done: state left unchanged on purpose
// Optional feature macro: TSETLIN_GATE_EN (probabilistic gating of updates by
// an LFSR compared against PROB_THRESH).
// -----------------------------------------------------------------------------
module tsetlin_state_update
    import tsetlin_pkg::*;
#(
    parameter logic [2:0] INIT_STATE  = 3'd3,
    parameter logic [7:0] PROB_THRESH = 8'd64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fb_valid,
    output logic       fb_ready,
    input  logic [1:0] fb_type,
    output logic       next_b2,
    output logic       next_b1,
    output logic       next_b0,
    output logic       action,
    output logic       upd_done,
    output logic       upd_skipped
);

    ta_fsm_e                 fsm_r;
    ta_fsm_e                 fsm_nxt_s;
    logic                    fb_ready_r;
    logic [1:0]              fb_type_r;
    logic [1:0]              fb_eff_s;
    logic [TA_STATE_W-1:0]   state_r;
    logic [TA_STATE_W-1:0]   cand_r;
    logic                    skip_r;
    logic [TA_STATE_W:0]     eval_s;
    logic                    upd_done_r;
    logic                    upd_skipped_r;
    logic                    accept_s;

    assign accept_s = fb_valid & fb_ready_r;

`ifdef TSETLIN_GATE_EN
    logic [7:0] lfsr_s;

    tsetlin_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_s)
    );

    // A gated-off command degrades to inaction so it is reported as skipped.
    always_comb begin
        fb_eff_s = FB_NONE;
        if (lfsr_s < PROB_THRESH) begin
            fb_eff_s = fb_type_r;
        end else begin
            fb_eff_s = FB_NONE;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{PROB_THRESH, LFSR_SEED};

    // Without gating every latched command is applied as-is.
    always_comb begin
        fb_eff_s = fb_type_r;
    end
`endif

    assign eval_s = ta_next(state_r, fb_eff_s);

    // Next-state logic of the IDLE/EVAL/WRITE controller.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            IDLE: begin
                if (fb_valid) begin
                    fsm_nxt_s = EVAL;
                end else begin
                    fsm_nxt_s = IDLE;
                end
            end
            EVAL:    fsm_nxt_s = WRITE;
            WRITE:   fsm_nxt_s = IDLE;
            default: fsm_nxt_s = IDLE;
        endcase
    end

    // Controller state, command latch, candidate holding register and the
    // committed state; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r         <= IDLE;
            fb_ready_r    <= 1'b1;
            fb_type_r     <= FB_NONE;
            cand_r        <= INIT_STATE;
            skip_r        <= 1'b0;
            state_r       <= INIT_STATE;
            upd_done_r    <= 1'b0;
            upd_skipped_r <= 1'b0;
        end else begin
            fsm_r         <= fsm_nxt_s;
            fb_ready_r    <= (fsm_nxt_s == IDLE);
            if (accept_s) begin
                fb_type_r <= fb_type;
            end
            if (fsm_r == EVAL) begin
                skip_r <= eval_s[TA_STATE_W];
                cand_r <= eval_s[TA_STATE_W-1:0];
            end
            if (fsm_r == WRITE) begin
                state_r <= cand_r;
            end
            upd_done_r    <= (fsm_r == WRITE);
            upd_skipped_r <= (fsm_r == WRITE) & skip_r;
        end
    end

    assign fb_ready    = fb_ready_r;
    assign next_b2     = state_r[2];
    assign next_b1     = state_r[1];
    assign next_b0     = state_r[0];
    assign action      = state_r[TA_INCLUDE_BIT];
    assign upd_done    = upd_done_r;
    assign upd_skipped = upd_skipped_r;

endmodule

// File: tb/tb_tsetlin_state_update.sv
module tb_tsetlin_state_update;

    logic       clk = 1'b0;
    logic       rst;
    logic       fb_valid;
    logic       fb_ready;
    logic [1:0] fb_type;
    logic       next_b2, next_b1, next_b0, action, upd_done, upd_skipped;

    int checks   = 0;
    int failures = 0;
    int ref_s;        // reference automaton state, plain integer 0..7
    int ref_skip;

    tsetlin_state_update dut (
        .clk         (clk),
        .rst         (rst),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .fb_type     (fb_type),
        .next_b2     (next_b2),
        .next_b1     (next_b1),
        .next_b0     (next_b0),
        .action      (action),
        .upd_done    (upd_done),
        .upd_skipped (upd_skipped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_state();
        return {29'd0, next_b2, next_b1, next_b0};
    endfunction

    // Reference rule: states 0..3 exclude, 4..7 include.
    // Reward moves away from the middle (clamped to 0..7), penalty toward and
    // across it, anything else leaves the state alone and is a skip.
    task automatic model(input int t);
        ref_skip = 0;
        if (t == 1) begin
            if (ref_s >= 4) ref_s = (ref_s + 1 > 7) ? 7 : ref_s + 1;
            else            ref_s = (ref_s - 1 < 0) ? 0 : ref_s - 1;
        end else if (t == 2) begin
            if (ref_s >= 4) ref_s = ref_s - 1;
            else            ref_s = ref_s + 1;
        end else begin
            ref_skip = 1;
        end
    endtask

    // One full transaction; busy-cycle inputs are randomised to show they are ignored.
    task automatic do_cmd(input int t, input string tag);
        int old_s;
        old_s = ref_s;
        @(negedge clk);
        check({tag, "_ready"}, fb_ready, 1);
        fb_valid = 1'b1;
        fb_type  = t[1:0];
        @(negedge clk);                   // EVAL
        fb_valid = 1'($urandom_range(0, 1));
        fb_type  = 2'($urandom_range(0, 3));
        check({tag, "_busy1"}, fb_ready, 0);
        check({tag, "_hold1"}, dut_state(), old_s);
        @(negedge clk);                   // WRITE
        fb_valid = 1'($urandom_range(0, 1));
        check({tag, "_busy2"}, fb_ready, 0);
        @(negedge clk);                   // committed
        fb_valid = 1'b0;
        model(t);
        check({tag, "_state"}, dut_state(), ref_s);
        check({tag, "_action"}, action, ref_s / 4);
        check({tag, "_done"}, upd_done, 1);
        check({tag, "_skip"}, upd_skipped, ref_skip);
        check({tag, "_ready_back"}, fb_ready, 1);
    endtask

    initial begin
        rst      = 1'b1;
        fb_valid = 1'b0;
        fb_type  = 2'b00;
        ref_s    = 3;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", dut_state(), 3);
        check("rst_action", action, 0);
        check("rst_ready", fb_ready, 1);
        check("rst_done", upd_done, 0);
        check("rst_skip", upd_skipped, 0);

        // 2. penalty across the boundary 3 -> 4
        do_cmd(2, "pen3");
        // 3. reward up to 7 and saturate
        repeat (3) do_cmd(1, "rew_up");
        do_cmd(1, "rew_sat7");
        check("sat7_value", dut_state(), 7);
        // walk down to 0 and saturate
        repeat (4) do_cmd(2, "pen_down");
        repeat (3) do_cmd(1, "rew_down");
        do_cmd(1, "rew_sat0");
        check("sat0_value", dut_state(), 0);
        // 4. inaction and reserved
        do_cmd(0, "inact");
        do_cmd(3, "rsvd");
        // climb to 4
        repeat (4) do_cmd(2, "pen_up");
        check("at4", dut_state(), 4);

        // 5. back-to-back: valid held high with penalty for 9 cycles
        begin
            int accepts = 0;
            @(negedge clk);
            fb_valid = 1'b1;
            fb_type  = 2'b10;
            for (int i = 0; i < 9; i++) begin
                check("b2b_ready", fb_ready, (i % 3 == 0) ? 1 : 0);
                if (i % 3 == 0 && i > 0) begin
                    model(2);
                    check("b2b_done", upd_done, 1);
                end
                check("b2b_state", dut_state(), ref_s);
                if (fb_ready) accepts++;
                @(negedge clk);
            end
            fb_valid = 1'b0;
            model(2);
            check("b2b_final_state", dut_state(), ref_s);
            check("b2b_final_done", upd_done, 1);
            check("b2b_accepts", accepts, 3);
            check("b2b_seq_end", ref_s, 3);
        end

        // 6. reset during EVAL suppresses the commit
        do_cmd(2, "pen_to4");
        @(negedge clk);
        fb_valid = 1'b1;
        fb_type  = 2'b10;
        @(negedge clk);                   // in EVAL
        fb_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_s = 3;
        check("midrst_state", dut_state(), 3);
        check("midrst_done", upd_done, 0);
        check("midrst_ready", fb_ready, 1);
        @(negedge clk);
        check("midrst_done2", upd_done, 0);
        @(negedge clk);
        check("midrst_done3", upd_done, 0);
        check("midrst_state2", dut_state(), 3);

        // randomised commands against the reference model
        for (int k = 0; k < 60; k++) begin
            do_cmd(int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
